// File: rtl/wide_word_pkg.sv
// Shared widths, types and header default for the wide word assembler.
// Beats are packed LSB-first; the last beat only partially fills the word.
package wide_word_pkg;

  localparam int BEAT_W = 32;
  localparam int WORD_W = 121;
  localparam int NBEATS = (WORD_W + BEAT_W - 1) / BEAT_W;
  localparam int ACC_W  = (NBEATS - 1) * BEAT_W;
  localparam int LAST_W = WORD_W - ACC_W;
  localparam int PAD_W  = NBEATS * BEAT_W - WORD_W;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int CNT_W  = 16;
  localparam int TAG_W  = 64;

  localparam logic [31:0] HDR_DEFAULT = 32'h0BD0_0000;

  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  function automatic logic is_last_beat(input idx_t k);
    return k == idx_t'(NBEATS - 1);
  endfunction

endpackage

// File: rtl/xz_beat_checker.sv
// Combinational X/Z detector for one input beat (4-state only).
// Compiled only when WIDE_WORD_ASSEMBLER_XZ_CHECK_EN is defined.
`ifdef WIDE_WORD_ASSEMBLER_XZ_CHECK_EN
module xz_beat_checker
  import wide_word_pkg::*;
(
  input  logic [BEAT_W-1:0] beat,
  output logic              has_xz
);

  // Any X or Z bit poisons the reduction XOR, which case-equality can see.
  assign has_xz = ((^beat) === 1'bx);

endmodule
`endif

// File: rtl/wide_word_assembler.sv
// Packs NBEATS input beats into one registered WORD_W-bit word with a tagged view.
// Optional sticky X/Z monitor on accepted beats: WIDE_WORD_ASSEMBLER_XZ_CHECK_EN.
module wide_word_assembler
  import wide_word_pkg::*;
#(
  parameter logic [31:0] HDR = HDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              xz_seen
);

  idx_t  k_reg, k_next;
  logic  out_valid_reg, out_valid_next;
  word_t out_word_reg, out_word_next;
  cnt_t  word_cnt_reg, word_cnt_next;
  logic  [ACC_W-1:0] acc;

  logic last_beat;
  logic in_fire;
  logic out_fire;

  assign last_beat = is_last_beat(k_reg);
  // The last beat may only land once the held word has gone or is leaving now.
  assign in_ready  = !(last_beat && out_valid_reg && !out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_reg && out_ready;

  // One register slot per non-final beat position.
  generate
    for (genvar gi = 0; gi < NBEATS - 1; gi++) begin : g_slot
      beat_t slot_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (in_fire && k_reg == idx_t'(gi)) begin
          slot_reg <= in_data;
        end
      end

      assign acc[gi*BEAT_W +: BEAT_W] = slot_reg;
    end
  endgenerate

  // Top bits of the final beat fall outside the word and are dropped.
  generate
    if (PAD_W > 0) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^in_data[BEAT_W-1:LAST_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg         <= '0;
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
      word_cnt_reg  <= '0;
    end else begin
      k_reg         <= k_next;
      out_valid_reg <= out_valid_next;
      out_word_reg  <= out_word_next;
      word_cnt_reg  <= word_cnt_next;
    end
  end

  always_comb begin
    k_next         = k_reg;
    out_valid_next = out_valid_reg;
    out_word_next  = out_word_reg;
    word_cnt_next  = word_cnt_reg;

    if (out_fire) begin
      out_valid_next = 1'b0;
      word_cnt_next  = word_cnt_reg + cnt_t'(1);
    end

    // A new word overrides the drain above when both happen together.
    if (in_fire) begin
      if (last_beat) begin
        k_next         = '0;
        out_valid_next = 1'b1;
        out_word_next  = {in_data[LAST_W-1:0], acc};
      end else begin
        k_next = k_reg + idx_t'(1);
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_word  = out_word_reg;
  assign out_tag   = {HDR, out_word_reg[31:0]};
  assign word_cnt  = word_cnt_reg;

`ifdef WIDE_WORD_ASSEMBLER_XZ_CHECK_EN
  logic beat_has_xz;
  logic xz_seen_reg;

  xz_beat_checker u_xz_beat_checker (
    .beat   (in_data),
    .has_xz (beat_has_xz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      xz_seen_reg <= 1'b0;
    end else if (in_fire && beat_has_xz) begin
      xz_seen_reg <= 1'b1;
    end
  end

  assign xz_seen = xz_seen_reg;
`else
  assign xz_seen = 1'b0;
`endif

endmodule

// File: tb/tb_wide_word_assembler.sv
// Directed bench for wide_word_assembler: packing, stalls, throughput, reset, wrap, X/Z flag.
module tb_wide_word_assembler;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         out_valid;
  logic         out_ready;
  logic [120:0] out_word;
  logic [63:0]  out_tag;
  logic [15:0]  word_cnt;
  logic         xz_seen;

  int total = 0;
  int bad   = 0;
  int accepted;
  logic xz_exp;
  logic [31:0] xz_beat;

  wide_word_assembler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_tag   (out_tag),
    .word_cnt  (word_cnt),
    .xz_seen   (xz_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One beat handshake, waiting a bounded number of cycles for in_ready.
  task automatic send(input logic [31:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("send_ready", {127'd0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
    $display("beat %h accepted, out_valid=%0d word_cnt=%0d", b, out_valid, word_cnt);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_word", {7'd0, out_word}, 128'd0);
    check("rst_out_tag", {64'd0, out_tag}, {64'd0, 64'h0BD0_0000_0000_0000});
    check("rst_word_cnt", {112'd0, word_cnt}, 128'd0);
    check("rst_xz_seen", {127'd0, xz_seen}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // First word, last beat carries discarded upper bits
    out_ready = 1'b1;
    send(32'h0000_0001);
    send(32'h0000_0002);
    send(32'h0000_0003);
    send(32'hFFFF_FFFF);
    check("w0_valid", {127'd0, out_valid}, 128'd1);
    check("w0_word", {7'd0, out_word}, {7'd0, 121'h1FFFFFF_00000003_00000002_00000001});
    check("w0_tag", {64'd0, out_tag}, {64'd0, 64'h0BD0_0000_0000_0001});
    check("w0_cnt_before", {112'd0, word_cnt}, 128'd0);
    step();
    check("w0_cnt_after", {112'd0, word_cnt}, 128'd1);
    check("w0_drained", {127'd0, out_valid}, 128'd0);
    $display("word handshake, word_cnt=%0d", word_cnt);

    // Held word stalls only the last beat of the next one
    out_ready = 1'b0;
    send(32'h0000_0005);
    send(32'h0000_0006);
    send(32'h0000_0007);
    send(32'h0000_0008);
    check("w1_word", {7'd0, out_word}, {7'd0, 121'h0000008_00000007_00000006_00000005});
    send(32'h0000_0009);
    send(32'h0000_000A);
    send(32'h0000_000B);
    in_data  = 32'h0000_000C;
    in_valid = 1'b1;
    #1;
    check("stall_ready0", {127'd0, in_ready}, 128'd0);
    step();
    check("stall_ready1", {127'd0, in_ready}, 128'd0);
    check("stall_word", {7'd0, out_word}, {7'd0, 121'h0000008_00000007_00000006_00000005});
    check("stall_tag", {64'd0, out_tag}, {64'd0, 64'h0BD0_0000_0000_0005});
    check("stall_cnt", {112'd0, word_cnt}, 128'd1);
    out_ready = 1'b1;
    #1;
    check("release_ready", {127'd0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
    $display("beat 0000000c accepted with simultaneous word handshake");
    check("w2_valid", {127'd0, out_valid}, 128'd1);
    check("w2_word", {7'd0, out_word}, {7'd0, 121'h000000C_0000000B_0000000A_00000009});
    check("w2_cnt", {112'd0, word_cnt}, 128'd2);
    step();
    check("w2_cnt_after", {112'd0, word_cnt}, 128'd3);

    // Back-to-back words at full rate
    accepted = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_data = 32'h1000_0000 + 32'(i);
      if (in_ready) accepted++;
      step();
      $display("stream beat %0d data %h", i, in_data);
    end
    in_valid = 1'b0;
    check("stream_accepted", 128'(accepted), 128'd32);
    check("stream_last_word", {7'd0, out_word}, {7'd0, 121'h000001F_1000001E_1000001D_1000001C});
    check("stream_cnt_mid", {112'd0, word_cnt}, 128'd10);
    step();
    check("stream_cnt_end", {112'd0, word_cnt}, 128'd11);

    // Reset in the middle of a word
    send(32'hDEAD_0001);
    send(32'hDEAD_0002);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_cnt", {112'd0, word_cnt}, 128'd0);
    check("midrst_valid", {127'd0, out_valid}, 128'd0);
    send(32'h0000_0021);
    send(32'h0000_0022);
    send(32'h0000_0023);
    send(32'h0000_0024);
    check("midrst_word", {7'd0, out_word}, {7'd0, 121'h0000024_00000023_00000022_00000021});
    step();
    check("midrst_cnt_after", {112'd0, word_cnt}, 128'd1);

    // Counter wrap from preloaded 16'hFFFF
    force dut.word_cnt_reg = 16'hFFFF;
    #1;
    release dut.word_cnt_reg;
    step();
    check("wrap_preload", {112'd0, word_cnt}, {112'd0, 16'hFFFF});
    send(32'h0000_0031);
    send(32'h0000_0032);
    send(32'h0000_0033);
    send(32'h0000_0034);
    check("wrap_before", {112'd0, word_cnt}, {112'd0, 16'hFFFF});
    step();
    check("wrap_after", {112'd0, word_cnt}, 128'd0);

    // X/Z monitor
`ifdef WIDE_WORD_ASSEMBLER_XZ_CHECK_EN
    xz_exp = 1'b1;
`else
    xz_exp = 1'b0;
`endif
    xz_beat = 32'b0000_1011_1101_xzxz_zxzx_zzzz_xxxx_0000;
    send(xz_beat);
    check("xz_set", {127'd0, xz_seen}, {127'd0, xz_exp});
    send(32'h0000_0042);
    send(32'h0000_0043);
    send(32'h0000_0044);
    check("xz_sticky", {127'd0, xz_seen}, {127'd0, xz_exp});
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("xz_cleared", {127'd0, xz_seen}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wide_word_assembler.md
Name: wide_word_assembler

Overview:
- Upstream feeder for the 121-bit wide-constant test block.
- Accepts 32-bit beats over a valid/ready stream and packs four beats into one 121-bit word. Beat 0 goes to the LSBs.
- Also emits a 64-bit tagged view of each word: a 32-bit header constant concatenated with word bits [31:0].
- Registered output with a one-word skid, so full throughput is one word per 4 accepted beats.

Parameters:
- BEAT_W, 32, input beat width.
- WORD_W, 121, assembled word width; must satisfy WORD_W <= NBEATS*BEAT_W.
- HDR, 32'h0BD0_0000, header placed in out_tag[63:32].
- NBEATS (localparam), ceil(WORD_W/BEAT_W) = 4, beats per word.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  BEAT_W  beat payload.
- out_valid  out  1  word valid.
- out_ready  in  1  consumer accepts word when out_valid && out_ready.
- out_word  out  WORD_W  assembled word.
- out_tag  out  64  {HDR, out_word[31:0]}.
- word_cnt  out  16  count of words handed off (out handshake), wraps at 2^16.
- xz_seen  out  1  sticky X/Z flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at clk edge):
  - beat index = 0, acc = 0, out_valid = 0, out_word = 0, word_cnt = 0, xz_seen = 0.
  - out_tag = {HDR, 32'h0}.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-word discards the partial accumulation; reset with a held word drops it.
- Beat index and accumulation:
  - Beat index k runs 0..NBEATS-1 and advances only on an input handshake.
  - Beat k < NBEATS-1 writes acc[k*BEAT_W +: BEAT_W].
  - The last beat supplies bits [WORD_W-1:(NBEATS-1)*BEAT_W]. Its upper NBEATS*BEAT_W-WORD_W bits (7 by default) are discarded, whatever their value.
- Last-beat handshake: word = {last beat slice, acc low bits} loads into out_word, out_valid=1, k wraps to 0. Latency is 1 cycle: out_valid rises the cycle after the last beat is accepted.
- in_ready:
  - Equals !(k==NBEATS-1 && out_valid && !out_ready).
  - Beats 0..NBEATS-2 are never stalled.
  - The last beat stalls only while a previous word is held and not drained.
  - in_ready must not depend on in_valid.
- Simultaneous last-beat accept and output handshake in the same cycle: the new word replaces the old one, out_valid stays 1 and word_cnt increments by 1.
- Output handshake without a new word: out_valid -> 0; out_word holds its last value (don't-care to the consumer).
- Output stability: out_word and out_tag are stable while out_valid && !out_ready.
- word_cnt: +1 per output handshake; 16'hFFFF + 1 = 16'h0000.
- No combinational path from in_data to any output.
- FSM: states are implicit in {k, out_valid}; no other state.

Optional Feature:
- Macro: WIDE_WORD_ASSEMBLER_XZ_CHECK_EN.
- Defined:
  - On each input handshake, if any bit of in_data is X or Z (4-state case-equality test on the reduction XOR), xz_seen sets to 1.
  - xz_seen is sticky until rst.
  - Beat data is still packed unchanged, so X/Z propagates into out_word.
- Undefined: xz_seen is tied to 0 and no 4-state comparisons are compiled, so the block is 2-state clean for Verilator.

Decomposition:
- Package wide_word_pkg holds:
  - BEAT_W, WORD_W, NBEATS, and the HDR default.
  - typedef beat_t (logic [BEAT_W-1:0]) and typedef word_t (logic [WORD_W-1:0]).
  - typedef idx_t, sized $clog2(NBEATS).
- One sub-module, xz_beat_checker, holds the comb X/Z detect on one beat. It is instantiated only under the macro.

Test Plan:
- Reset then 4 beats 32'h00000001, 32'h00000002, 32'h00000003, 32'hFFFFFFFF, out_ready=1 -> one cycle later out_valid=1, out_word = 121'h1FFFFFF_00000003_00000002_00000001, out_tag = 64'h0BD0_0000_0000_0001, word_cnt becomes 1 after handshake.
- out_ready=0 with a word held, then 4 more beats -> first 3 accepted, 4th stalls (in_ready=0), out_word unchanged; raise out_ready -> last beat accepted same cycle, second word appears next cycle, word_cnt=1 then 2.
- Continuous in_valid and out_ready for 8 words -> exactly 32 beat handshakes in 32 cycles, no bubbles, word_cnt=8.
- Assert rst after 2 beats of a word, then send 4 new beats -> output equals only the new beats; no stale acc bits.
- Force word_cnt to 16'hFFFF via 65535 words (or preload in sim), one more handshake -> word_cnt=16'h0000.
- With WIDE_WORD_ASSEMBLER_XZ_CHECK_EN: beat 32'b0000_1011_1101_xzxz_zxzx_zzzz_xxxx_0000 -> xz_seen=1 next cycle and stays 1 through later clean beats until rst. Without the macro: the same stimulus leaves xz_seen=0.
